// File: rtl/vga_pkg.sv
// Shared VGA timing constants, raster-total helpers and colour types.
package vga_pkg;

   // 640x480 @ 60 Hz industry timing (25 MHz pixel clock)
   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;

   localparam int CNT_W = 11;

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Per-pixel control flags carried alongside the layer latency
   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } sync_t;

   // Syncs deasserted, outside the visible area
   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

   // Replicate MSBs so full-scale 3/2-bit codes map to full-scale 4-bit DAC codes
   function automatic rgb444_t expand(input rgb332_t c);
      rgb444_t o;
      o.r = {c.r, c.r[2]};
      o.g = {c.g, c.g[2]};
      o.b = {c.b, c.b};
      return o;
   endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-rate divider, raster counters and raw sync/active decode.
module vga_timing_counter
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int CLK_DIV  = 2
) (
   input  logic             clk,
   input  logic             reset,
   output logic             pixelTick,
   output logic [CNT_W-1:0] hCnt,
   output logic [CNT_W-1:0] vCnt,
   output logic             inActive,
   output logic             hsRaw,
   output logic             vsRaw,
   output logic             startOfFrame
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] divCnt;
   logic          hWrap;
   logic          vWrap;

   assign pixelTick = (divCnt == DIV_LAST);
   assign hWrap     = (hCnt == H_LAST);
   assign vWrap     = (vCnt == V_LAST);

   // System-clock divider; with CLK_DIV=1 it stays at 0 and ticks every clk
   always_ff @(posedge clk) begin
      if (reset)          divCnt <= '0;
      else if (pixelTick) divCnt <= '0;
      else                divCnt <= divCnt + 1'b1;
   end

   // Raster position advances once per pixel tick
   always_ff @(posedge clk) begin
      if (reset) begin
         hCnt <= '0;
         vCnt <= '0;
      end else if (pixelTick) begin
         if (hWrap) begin
            hCnt <= '0;
            vCnt <= vWrap ? '0 : vCnt + 1'b1;
         end else begin
            hCnt <= hCnt + 1'b1;
         end
      end
   end

   // Frame-start strobe lines up with the first clk showing (0,0) after a wrap
   always_ff @(posedge clk) begin
      if (reset) startOfFrame <= 1'b0;
      else       startOfFrame <= pixelTick && hWrap && vWrap;
   end

   assign inActive = (hCnt < H_ACT) && (vCnt < V_ACT);
   assign hsRaw    = !((hCnt >= HS_START) && (hCnt < HS_END));
   assign vsRaw    = !((vCnt >= VS_START) && (vCnt < VS_END));

endmodule

// File: rtl/vga_pixel_sink.sv
// Raster generator plus latency-matched sync/colour output stage to the VGA DAC.
module vga_pixel_sink
   import vga_pkg::*;
#(
   parameter int H_ACTIVE      = H_ACTIVE_D,
   parameter int H_FP          = H_FP_D,
   parameter int H_SYNC        = H_SYNC_D,
   parameter int H_BP          = H_BP_D,
   parameter int V_ACTIVE      = V_ACTIVE_D,
   parameter int V_FP          = V_FP_D,
   parameter int V_SYNC        = V_SYNC_D,
   parameter int V_BP          = V_BP_D,
   parameter int CLK_DIV       = 2,
   parameter int LAYER_LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       RGBin,
   output logic [CNT_W-1:0] pixelX,
   output logic [CNT_W-1:0] pixelY,
   output logic             inActive,
   output logic             pixelTick,
   output logic             startOfFrame,
   output logic [3:0]       VGA_R,
   output logic [3:0]       VGA_G,
   output logic [3:0]       VGA_B,
   output logic             VGA_HS,
   output logic             VGA_VS
);

   logic    hsRaw;
   logic    vsRaw;
   sync_t   raw;
   sync_t   dly;
   rgb444_t rgbOut;

   vga_timing_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .CLK_DIV  (CLK_DIV)
   ) u_timing (
      .clk          (clk),
      .reset        (reset),
      .pixelTick    (pixelTick),
      .hCnt         (pixelX),
      .vCnt         (pixelY),
      .inActive     (inActive),
      .hsRaw        (hsRaw),
      .vsRaw        (vsRaw),
      .startOfFrame (startOfFrame)
   );

   assign raw = '{hs: hsRaw, vs: vsRaw, act: inActive};

   // Delay the control flags by the layer latency so they meet the colour
   // computed for the same coordinate
   generate
      if (LAYER_LATENCY == 0) begin : g_nodly
         assign dly = raw;
      end else begin : g_dly
         sync_t [LAYER_LATENCY-1:0] pipe;

         // Shift one slot per pixel tick; cleared to idle so reset never
         // lets a stale sync-low reach the pins
         always_ff @(posedge clk) begin
            if (reset) begin
               pipe <= {LAYER_LATENCY{SYNC_IDLE}};
            end else if (pixelTick) begin
               for (int i = LAYER_LATENCY - 1; i > 0; i--) pipe[i] <= pipe[i-1];
               pipe[0] <= raw;
            end
         end

         assign dly = pipe[LAYER_LATENCY-1];
      end
   endgenerate

   // Output register: syncs and blanked colour change together on the tick
   always_ff @(posedge clk) begin
      if (reset) begin
         VGA_HS <= 1'b1;
         VGA_VS <= 1'b1;
         rgbOut <= '0;
      end else if (pixelTick) begin
         VGA_HS <= dly.hs;
         VGA_VS <= dly.vs;
         rgbOut <= dly.act ? expand(rgb332_t'(RGBin)) : '0;
      end
   end

   assign VGA_R = rgbOut.r;
   assign VGA_G = rgbOut.g;
   assign VGA_B = rgbOut.b;

endmodule
